iiitb_sqg: RTL
==============

Name: iiitb_sqg

Overview:
Serial pattern generator. It is the transmit end of the "1010" sequence-detector link and drives the detector's serial din input. It loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock. The pattern is sent a programmable number of times, with optional idle gap cycles between repeats. It produces stimulus for the detector and serves as a source block in the system demo.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of the repeat-count input
GAP, 0, idle cycles inserted between consecutive repeats (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  request; sampled only in IDLE
pattern  input  PAT_W  bits to send, MSB first
repeat  input  CNT_W  number of pattern transmissions
dout  output  1  serial data, to detector din
dvalid  output  1  dout carries a pattern bit this cycle
busy  output  1  high from the cycle after start is accepted until DONE completes
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async): state IDLE; dout=0, dvalid=0, busy=0, done=0. Shift register and counters are cleared. Reset mid-frame aborts the frame; no done pulse. After release, the block waits for a new start.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at edge N: capture pattern into the shift register and repeat into rep_cnt.
  - If repeat=0: go to DONE. Result: done=1 in cycle N+1, dvalid never asserted.
  - Otherwise: go to SHIFT; bit_cnt=PAT_W-1.
- SHIFT:
  - dout = shift-register MSB; dvalid=1; busy=1.
  - First bit appears in cycle N+1.
  - Register shifts left one per clock; bit_cnt decrements.
  - On the last bit (bit_cnt=0), rep_cnt decrements.
  - If rep_cnt becomes 0: go to DONE.
  - Else if GAP>0: go to GAP.
  - Else: reload the captured pattern and stay in SHIFT with no bubble.
- GAP: dout=0, dvalid=0, busy=1 for exactly GAP cycles. Then reload the pattern and go to SHIFT.
- DONE: done=1, busy=1, dvalid=0 for one cycle, then IDLE. busy drops in the cycle after done.
- Total dvalid cycles = repeat*PAT_W. Frame length = repeat*PAT_W + (repeat-1)*GAP cycles.
- start while busy is ignored; there is no queueing.
- pattern and repeat are sampled only at start acceptance. Later changes have no effect on the frame in progress.
- rep_cnt is CNT_W wide. repeat = 2^CNT_W-1 is legal, and the count must not wrap.
- start held high continuously: a new frame begins in the cycle after DONE, i.e. at least one IDLE cycle between frames.

Optional Feature:
Macro IIITB_SQG_PARITY_EN.
- Defined: after each pattern repetition, one extra bit with dvalid=1 is sent, carrying the even-parity bit (XOR of the pattern bits). This bit precedes GAP/DONE. dvalid cycles = repeat*(PAT_W+1).
- Undefined: no parity bit; behaviour exactly as above.

Decomposition:
- Package iiitb_sqg_pkg:
  - state enum (IDLE, SHIFT, GAP, DONE)
  - default widths PAT_W_DEF=4 and CNT_W_DEF=4
  - constant DET_PATTERN=4'b1010 shared with the detector bench
- Sub-module iiitb_sqg_shreg: parameterised PAT_W load/shift-left register with MSB output, async active-low clear, and load/shift enables. The FSM and counters stay in the top level.

Test Plan:
1. pattern=1010, repeat=1, GAP=0, start at cycle 0 -> dout=1,0,1,0 in cycles 1-4 with dvalid=1; done=1 in cycle 5; busy=0 in cycle 6. Looped into iiitb_sqd_1010: y pulses once.
2. pattern=1010, repeat=3, GAP=0 -> 12 contiguous bits 101010101010; dvalid continuous; done in cycle 13. Detector reports overlapping matches per its spec.
3. pattern=1010, repeat=2, GAP=2 -> bits in cycles 1-4, dvalid=0 in cycles 5-6, bits in cycles 7-10, done in cycle 11.
4. repeat=0, start at cycle 0 -> done=1 in cycle 1; dvalid stays 0 throughout.
5. start pulsed again in cycle 2 of a frame, with pattern changed to 1111 -> ignored; the in-flight frame still sends 1010.
6. reset=0 asserted asynchronously mid-cycle 2 of a frame -> dout/dvalid/busy go to 0 immediately; no done pulse. A fresh start after release sends the full pattern from its MSB.

Source files
------------

// File: rtl/iiitb_sqg_pkg.sv
// -----------------------------------------------------------------------------
// iiitb_sqg_pkg
// Shared types and constants for the serial pattern generator (iiitb_sqg).
//   state_t      : FSM state encoding (idle, shifting, inter-repeat gap, done)
//   PAT_W_DEF    : default pattern width
//   CNT_W_DEF    : default repeat-count width
//   DET_PATTERN  : the "1010" pattern the downstream sequence detector looks for
// -----------------------------------------------------------------------------
package iiitb_sqg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 4;

    localparam logic [3:0] DET_PATTERN = 4'b1010;

endpackage : iiitb_sqg_pkg

// File: rtl/iiitb_sqg_if.sv
// -----------------------------------------------------------------------------
// iiitb_sqg_if
// Request/serial-output bundle of the pattern generator.
//   start      : frame request (master -> generator)
//   pattern    : PAT_W bits to send, MSB first
//   repeat_val : number of pattern transmissions ("repeat" is a keyword)
//   dout       : serial data towards the detector din
//   dvalid     : dout carries a pattern (or parity) bit
//   busy       : a frame is in progress
//   done       : one-cycle completion pulse
// Modports: master drives the request, slave is the generator.
// -----------------------------------------------------------------------------
interface iiitb_sqg_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_val;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_val,
        input  dout, dvalid, busy, done
    );

    modport slave (
        input  start, pattern, repeat_val,
        output dout, dvalid, busy, done
    );
endinterface : iiitb_sqg_if

// File: rtl/iiitb_sqg_shreg.sv
// -----------------------------------------------------------------------------
// iiitb_sqg_shreg
// PAT_W-bit load / shift-left register with MSB output.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low clear
//   clr_i   : synchronous clear (highest priority)
//   load_i  : load data_i
//   shift_i : shift left by one, zero fill
//   data_i  : parallel load value
//   msb_o   : register MSB (registered, drives serial output directly)
// -----------------------------------------------------------------------------
module iiitb_sqg_shreg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] data_i,
    output logic             msb_o
);

    logic [PAT_W-1:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (clr_i) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= data_i;
        end else if (shift_i) begin
            sh_q <= {sh_q[PAT_W-2:0], 1'b0};
        end
    end

    assign msb_o = sh_q[PAT_W-1];

endmodule : iiitb_sqg_shreg

// File: rtl/iiitb_sqg.sv
// -----------------------------------------------------------------------------
// iiitb_sqg
// Serial pattern generator: sends a captured PAT_W-bit pattern MSB first,
// repeat_val times, with GAP idle cycles between repetitions.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : iiitb_sqg_if.slave (start/pattern/repeat_val in,
//           dout/dvalid/busy/done out, all outputs registered)
// Optional build macro IIITB_SQG_PARITY_EN: append an even-parity bit
// (dvalid=1) after every repetition, before the gap or the done pulse.
// -----------------------------------------------------------------------------
module iiitb_sqg
    import iiitb_sqg_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP   = 0
) (
    input  logic        clk,
    input  logic        reset,
    iiitb_sqg_if.slave  bus
);

    localparam int BW = $clog2(PAT_W);

    state_t           state_q,   state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic             dvalid_q,  dvalid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
`ifdef IIITB_SQG_PARITY_EN
    logic             par_q,     par_d;
`endif

    logic             rep_end;
    logic             sh_clr;
    logic             sh_load;
    logic             sh_shift;
    logic [PAT_W-1:0] sh_data;
    logic             sh_msb;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        pat_d     = pat_q;
        dvalid_d  = dvalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef IIITB_SQG_PARITY_EN
        par_d     = par_q;
`endif
        rep_end   = 1'b0;
        sh_clr    = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_data   = pat_q;

        case (state_q)
            ST_IDLE: begin
                dvalid_d = 1'b0;
                busy_d   = 1'b0;
                if (bus.start) begin
                    pat_d     = bus.pattern;
                    rep_cnt_d = bus.repeat_val;
                    busy_d    = 1'b1;
                    if (bus.repeat_val == '0) begin
                        // Zero repeats: keep the shifter empty so dout stays 0.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        sh_clr  = 1'b1;
                    end else begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = BW'(PAT_W - 1);
                        dvalid_d  = 1'b1;
                        sh_load   = 1'b1;
                        sh_data   = bus.pattern;
`ifdef IIITB_SQG_PARITY_EN
                        par_d     = 1'b0;
`endif
                    end
                end
            end

            ST_SHIFT: begin
`ifdef IIITB_SQG_PARITY_EN
                if (par_q) begin
                    rep_end = 1'b1;
                end else if (bit_cnt_q == '0) begin
                    // Parity bit rides in the shifter MSB for one cycle.
                    par_d   = 1'b1;
                    sh_load = 1'b1;
                    sh_data = {^pat_q, {(PAT_W-1){1'b0}}};
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    sh_shift  = 1'b1;
                end
`else
                if (bit_cnt_q == '0) begin
                    rep_end = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    sh_shift  = 1'b1;
                end
`endif
                if (rep_end) begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    // Test before decrementing so the maximum count never wraps.
                    if (rep_cnt_q == CNT_W'(1)) begin
                        state_d  = ST_DONE;
                        dvalid_d = 1'b0;
                        done_d   = 1'b1;
                        sh_clr   = 1'b1;
                    end else if (GAP > 0) begin
                        state_d   = ST_GAP;
                        dvalid_d  = 1'b0;
                        gap_cnt_d = 4'(GAP - 1);
                        sh_clr    = 1'b1;
                    end else begin
                        bit_cnt_d = BW'(PAT_W - 1);
                        sh_load   = 1'b1;
`ifdef IIITB_SQG_PARITY_EN
                        par_d     = 1'b0;
`endif
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = BW'(PAT_W - 1);
                    dvalid_d  = 1'b1;
                    sh_load   = 1'b1;
`ifdef IIITB_SQG_PARITY_EN
                    par_d     = 1'b0;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                dvalid_d = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                dvalid_d = 1'b0;
                sh_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            pat_q     <= '0;
            dvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef IIITB_SQG_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            pat_q     <= pat_d;
            dvalid_q  <= dvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef IIITB_SQG_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    iiitb_sqg_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (sh_clr),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (sh_data),
        .msb_o   (sh_msb)
    );

    assign bus.dout   = sh_msb;
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule : iiitb_sqg
